// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Initiator side of the word-addressed data memory port. Accepts
//            one load/store at a time, issues word-aligned transactions,
//            extracts and sign/zero-extends byte/half loads, and performs
//            sub-word stores as read-modify-write. Misaligned or illegal-size
//            requests complete without touching memory.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            req/op/addr/wdata - request strobe, {store,unsigned,size},
//                                byte address, store data
//            busy/done/rdata/misaligned - status and load result
//            memRead/memWrite/address/Writedata/Readdata - memory side
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int MEM_LAT    = 1,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] Writedata,
  input  logic [31:0] Readdata
);

  localparam int c_CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_op;
  logic [31:0]       r_addr;
  logic [15:0]       r_wdata;     // only the low half matters for sub-word merges
  logic [31:0]       r_wrdata;
  logic [31:0]       r_rdata;
  logic              r_mis;
  logic [c_CW-1:0]   r_wait;

  logic              w_misreq;
  logic              w_word_st;
  logic              w_last;
  logic [1:0]        w_lane;
  logic [4:0]        w_shamt;
  logic [15:0]       w_lane16;
  logic [31:0]       w_load;
  logic [31:0]       w_mask;
  logic [31:0]       w_merged;

  // Request classification works on the live inputs so the decision is made
  // in the accept cycle itself.
  assign w_misreq  = (op[1:0] == 2'b11) ||
                     ((op[1:0] == 2'b01) && addr[0]) ||
                     ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_word_st = op[3] && (op[1:0] == 2'b10);
  assign w_last    = (r_wait == c_LAST);

  // Lane index in units of bytes, counted from bit 0 of the memory word.
  always_comb begin
    w_lane = 2'd0;
    case (r_op[1:0])
      2'b00:   w_lane = BIG_ENDIAN ? (2'd3 - r_addr[1:0]) : r_addr[1:0];
      2'b01:   w_lane = BIG_ENDIAN ? (2'd2 - r_addr[1:0]) : r_addr[1:0];
      default: w_lane = 2'd0;
    endcase
  end

  assign w_shamt  = {w_lane, 3'b000};
  assign w_lane16 = 16'(Readdata >> w_shamt);

  always_comb begin
    w_load = Readdata;
    w_mask = 32'hFFFF_FFFF;
    case (r_op[1:0])
      2'b00: begin
        w_load = r_op[2] ? {24'h0, w_lane16[7:0]} : {{24{w_lane16[7]}}, w_lane16[7:0]};
        w_mask = 32'h0000_00FF << w_shamt;
      end
      2'b01: begin
        w_load = r_op[2] ? {16'h0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
        w_mask = 32'h0000_FFFF << w_shamt;
      end
      default: begin
        w_load = Readdata;
        w_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign w_merged = (Readdata & ~w_mask) | (({16'h0, r_wdata} << w_shamt) & w_mask);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_misreq)       w_next = S_DONE;
          else if (w_word_st) w_next = S_WR;
          else                w_next = S_RD;
        end
      end
      S_RD:    if (w_last) w_next = r_op[3] ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= 4'h0;
      r_addr   <= 32'h0;
      r_wdata  <= 16'h0;
      r_wrdata <= 32'h0;
      r_rdata  <= 32'h0;
      r_mis    <= 1'b0;
      r_wait   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait <= '0;
          if (req) begin
            r_op    <= op;
            r_addr  <= addr;
            r_wdata <= wdata[15:0];
            r_mis   <= w_misreq;
            if (!w_misreq && w_word_st) r_wrdata <= wdata;
          end
        end
        S_RD: begin
          if (w_last) begin
            if (r_op[3]) r_wrdata <= w_merged;
            else         r_rdata  <= w_load;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DONE:  r_mis <= 1'b0;
        default: ;
      endcase
    end
  end

  // Exactly one of memRead/memWrite is high in every state; idle is a read.
  assign memRead    = (r_state != S_WR);
  assign memWrite   = (r_state == S_WR);
  assign address    = {r_addr[31:2], 2'b00};
  assign Writedata  = r_wrdata;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign misaligned = r_mis;
  assign rdata      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Scoreboard bench for mem_access_ctrl. Two instances (MEM_LAT=1
//            and MEM_LAT=3, big-endian) receive identical requests. A byte
//            array reference model predicts load results, memory contents,
//            completion cycles and write cycles; a monitor checks them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  typedef struct {
    int          d;
    logic        mis;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  typedef struct {
    int          d;
    int          due;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  busy, done, mis, memRead, memWrite;
  logic [31:0] rdata_o   [2];
  logic [31:0] address_o [2];
  logic [31:0] wrdata_o  [2];
  logic [31:0] rddata_i  [2];
  logic [31:0] mem       [2][64];

  logic [7:0]  rb [0:255];
  logic [31:0] ref_rdata;
  rsp_t        rq[$];
  wr_t         wq[$];
  int          cyc = 0;
  int          bfrom[2] = '{-10, -10};
  int          bto[2]   = '{-10, -10};
  int          n_cmp = 0;
  int          n_bad = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_access_ctrl #(.MEM_LAT(gi == 0 ? 1 : 3), .BIG_ENDIAN(1'b1)) u_dut (
      .clk(clk), .reset(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy[gi]), .done(done[gi]), .rdata(rdata_o[gi]), .misaligned(mis[gi]),
      .memRead(memRead[gi]), .memWrite(memWrite[gi]), .address(address_o[gi]),
      .Writedata(wrdata_o[gi]), .Readdata(rddata_i[gi])
    );
    assign rddata_i[gi] = mem[gi][address_o[gi][7:2]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (memWrite[d]) mem[d][address_o[d][7:2]] <= wrdata_o[d];
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {rb[a], rb[a+1], rb[a+2], rb[a+3]};
  endfunction

  // Monitor: per-cycle protocol checks plus scoreboard pops on done/memWrite.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int idx;
      chk("rw_onehot", d, {31'b0, memRead[d] ^ memWrite[d]}, 32'd1);
      chk("busy", d, {31'b0, busy[d]}, {31'b0, (cyc >= bfrom[d]) && (cyc <= bto[d])});
      if (memWrite[d]) begin
        idx = -1;
        for (int i = 0; i < wq.size(); i++) if (wq[i].d == d && idx < 0) idx = i;
        if (idx < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write dut%0d cyc %0d: got memWrite=1 expected 0", d, cyc);
        end else begin
          chk("write_cycle", d, 32'(cyc), 32'(wq[idx].due));
          chk("write_addr", d, address_o[d], wq[idx].addr);
          chk("write_data", d, wrdata_o[d], wq[idx].data);
          wq.delete(idx);
        end
      end
      if (done[d]) begin
        idx = -1;
        for (int i = 0; i < rq.size(); i++) if (rq[i].d == d && idx < 0) idx = i;
        if (idx < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done dut%0d cyc %0d: got done=1 expected 0", d, cyc);
        end else begin
          chk("done_cycle", d, 32'(cyc), 32'(rq[idx].due));
          chk("misaligned", d, {31'b0, mis[d]}, {31'b0, rq[idx].mis});
          chk("rdata", d, rdata_o[d], rq[idx].rdata);
          rq.delete(idx);
        end
      end
    end
  end

  // Reference model update plus scoreboard push, then drive and wait.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [31:0] wd, input bit extra);
    int sz, n, k, lat, L, wa, cnt;
    logic misx;
    logic [31:0] v;
    sz   = int'(o[1:0]);
    misx = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    n    = 1 << sz;
    if (!misx) begin
      if (o[3]) begin
        for (int i = 0; i < n; i++) rb[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, rb[int'(a) + i]};
        if (!o[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        ref_rdata = v;
      end
    end
    wa = int'(a) & 32'hFC;
    k  = cyc;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      L   = misx ? 1 : (o[3] ? ((sz == 2) ? 2 : lat + 2) : lat + 1);
      rq.push_back('{d, misx, ref_rdata, k + L});
      if (o[3] && !misx)
        wq.push_back('{d, (sz == 2) ? k + 1 : k + lat + 1, 32'(wa), ref_word(wa)});
      bfrom[d] = k + 1;
      bto[d]   = k + L;
    end
    req = 1'b1; op = o; addr = {24'h0, a}; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    if (extra) begin
      req = 1'b1; op = 4'($urandom); addr = $urandom; wdata = $urandom;
      @(posedge clk); #1;
      req = 1'b0;
    end
    cnt = 0;
    while ((rq.size() != 0 || wq.size() != 0) && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout op %h addr %h: got %0d pending expected 0", o, a, rq.size() + wq.size());
      rq.delete();
      wq.delete();
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; req = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;
    ref_rdata = 32'h0;
    for (int w = 0; w < 64; w++) begin
      v = $urandom;
      if (w == 4) v = 32'h1122_3344;
      if (w == 8) v = 32'h80FF_0000;
      mem[0][w] = v;
      mem[1][w] = v;
      for (int b = 0; b < 4; b++) rb[4*w + b] = 8'(v >> (24 - 8 * b));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_done", d, {31'b0, done[d]}, 32'd0);
      chk("rst_mis", d, {31'b0, mis[d]}, 32'd0);
      chk("rst_rdata", d, rdata_o[d], 32'd0);
      chk("rst_memRead", d, {31'b0, memRead[d]}, 32'd1);
      chk("rst_memWrite", d, {31'b0, memWrite[d]}, 32'd0);
      chk("rst_address", d, address_o[d], 32'd0);
      chk("rst_Writedata", d, wrdata_o[d], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed loads (LB, LH, LW, then sign/zero extension on 0x80FF0000)
    issue(4'b0000, 8'h11, 32'h0, 1'b0);
    issue(4'b0001, 8'h12, 32'h0, 1'b0);
    issue(4'b0010, 8'h10, 32'h0, 1'b1);
    issue(4'b0000, 8'h20, 32'h0, 1'b0);
    issue(4'b0100, 8'h20, 32'h0, 1'b0);
    issue(4'b0001, 8'h20, 32'h0, 1'b0);
    issue(4'b0101, 8'h20, 32'h0, 1'b1);

    // Reset during the RD cycle of SB 0x13: no write, no done, rdata cleared
    begin
      int k;
      k = cyc;
      for (int d = 0; d < 2; d++) begin bfrom[d] = k + 1; bto[d] = k + 1; end
      req = 1'b1; op = 4'b1000; addr = 32'h13; wdata = 32'h0000_00CD;
      @(posedge clk); #1;
      req = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ref_rdata = 32'h0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("reset_mid_rdata", d, rdata_o[d], 32'd0);
        chk("reset_mid_word", d, mem[d][4], 32'h1122_3344);
      end
      @(posedge clk); #1;
    end

    // Sub-word store then read-back, misaligned rejects
    issue(4'b1000, 8'h13, 32'h0000_00AB, 1'b0);
    issue(4'b0010, 8'h10, 32'h0, 1'b0);
    issue(4'b1001, 8'h11, 32'h0000_BEEF, 1'b0);
    issue(4'b0010, 8'h12, 32'h0, 1'b1);
    issue(4'b0011, 8'h10, 32'h0, 1'b0);
    issue(4'b1010, 8'h24, 32'hDEAD_BEEF, 1'b0);
    issue(4'b1001, 8'h26, 32'h1234_5678, 1'b0);
    issue(4'b0010, 8'h24, 32'h0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      issue(4'($urandom), 8'($urandom), $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        chk("mem_word", d, mem[d][w], ref_word(4 * w));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
